// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM status and arbiter state types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Owner of the single RAM port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side signals of the memory arbiter
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // icache channel
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // dcache channel
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Caches plus RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - dcache-priority RAM port arbiter with icache starvation limit
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int            CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW:0]   SMAX = (CW + 1)'(STARVE_MAX);

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   scnt_q, scnt_d;
    logic [CW:0]     scnt_inc;
    logic            dreq;
    logic            acc;

    assign dreq     = bus.dREN | bus.dWEN;
    assign acc      = (bus.ramstate == ACCESS);
    assign scnt_inc = {1'b0, scnt_q} + 1'b1;

    // Read data is broadcast; only the wait flags say who may use it
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    // Owner and starvation counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // Next owner and count of dcache completions made while a fetch waits
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            IDLE: begin
                if (dreq && !(bus.iREN && ({1'b0, scnt_q} >= SMAX)))
                    state_d = DGRANT;
                else if (bus.iREN)
                    state_d = IGRANT;
            end
            DGRANT: begin
                if (!dreq) begin
                    state_d = bus.iREN ? IGRANT : IDLE;
                end else if (acc && bus.iREN) begin
                    // Hold the port across the dcache block until the fetch
                    // has waited out STARVE_MAX completions
                    if (scnt_inc >= SMAX) begin
                        scnt_d  = SMAX[CW-1:0];
                        state_d = IGRANT;
                    end else begin
                        scnt_d  = scnt_inc[CW-1:0];
                    end
                end
            end
            IGRANT: begin
                if (acc || !bus.iREN) begin
                    scnt_d = '0;
                    if (dreq)
                        state_d = DGRANT;
                    else if (bus.iREN)
                        state_d = IGRANT;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!bus.iREN)
            scnt_d = '0;
    end

    // RAM strobes and cache wait flags follow the current owner
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        case (state_q)
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~acc;
            end
            IGRANT: begin
                bus.ramREN   = bus.iREN;
                bus.ramaddr  = bus.iaddr;
                bus.iwait    = ~acc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int SM = 4;

    logic clk = 1'b0;
    logic nrst;
    int   passed = 0;
    int   total  = 0;

    // Reference: owner 0 = nobody, 1 = icache, 2 = dcache
    int   m_own;
    int   m_cnt;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int next_own();
        bit dreq = bus.dREN | bus.dWEN;
        bit acc  = (bus.ramstate == ACCESS);
        case (m_own)
            0: begin
                if (dreq && !(bus.iREN && m_cnt >= SM)) return 2;
                return bus.iREN ? 1 : 0;
            end
            2: begin
                if (!dreq) return bus.iREN ? 1 : 0;
                if (acc && bus.iREN && (m_cnt + 1) >= SM) return 1;
                return 2;
            end
            default: begin
                if (acc || !bus.iREN) return dreq ? 2 : (bus.iREN ? 1 : 0);
                return 1;
            end
        endcase
    endfunction

    function automatic int next_cnt();
        bit dreq = bus.dREN | bus.dWEN;
        bit acc  = (bus.ramstate == ACCESS);
        if (!bus.iREN) return 0;
        if (m_own == 2 && dreq && acc) return (m_cnt + 1 > SM) ? SM : m_cnt + 1;
        if (m_own == 1 && acc) return 0;
        return m_cnt;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_own <= 0;
            m_cnt <= 0;
        end else begin
            m_own <= next_own();
            m_cnt <= next_cnt();
        end
    end

    // {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload}
    function automatic logic [131:0] exp_vec();
        logic [131:0] v;
        bit acc = (bus.ramstate == ACCESS);
        case (m_own)
            2:       v = {1'b1, ~acc, bus.dREN & ~bus.dWEN, bus.dWEN, bus.daddr, bus.dstore,
                          bus.ramload, bus.ramload};
            1:       v = {~acc, 1'b1, bus.iREN, 1'b0, bus.iaddr, 32'h0, bus.ramload, bus.ramload};
            default: v = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, bus.ramload, bus.ramload};
        endcase
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
    endtask

    task automatic go_idle();
        cyc(); clear_inputs(); cyc(); cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        nrst = 0;
        cyc(); cyc(); settle();
        total++; if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN} !== 4'b1100)
            $display("FAIL reset_flags: got %b want 1100", {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN}); else passed++;
        total++; if ({bus.ramaddr, bus.ramstore} !== 64'h0)
            $display("FAIL reset_bus: got %h want 0", {bus.ramaddr, bus.ramstore}); else passed++;
        cyc(); nrst = 1;
    endtask

    task automatic test_reset_mid();
        go_idle();
        bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h55; bus.ramstate = BUSY;
        cyc(); settle();
        total++; if (bus.ramWEN !== 1'b1) $display("FAIL mid_wen_on: got %b want 1", bus.ramWEN); else passed++;
        #1 nrst = 0;
        #1;
        total++; if ({bus.ramWEN, bus.ramREN} !== 2'b00)
            $display("FAIL mid_wen_drop: got %b want 00", {bus.ramWEN, bus.ramREN}); else passed++;
        cyc(); nrst = 1; settle();
        total++; if (dut.state_q !== IDLE) $display("FAIL mid_state: got %0d want IDLE", dut.state_q); else passed++;
        total++; if ({bus.iwait, bus.dwait} !== 2'b11)
            $display("FAIL mid_waits: got %b want 11", {bus.iwait, bus.dwait}); else passed++;
        go_idle();
    endtask

    task automatic test_ifetch();
        go_idle();
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
        settle();
        total++; if (bus.ramREN !== 1'b0) $display("FAIL if_arb_cycle: got %b want 0", bus.ramREN); else passed++;
        for (int k = 0; k < 2; k++) begin
            cyc(); settle();
            total++; if ({bus.ramREN, bus.iwait, bus.ramaddr} !== {2'b11, 32'h40})
                $display("FAIL if_busy%0d: got %b%b %h want 11 40", k, bus.ramREN, bus.iwait, bus.ramaddr); else passed++;
        end
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h12345678; settle();
        total++; if ({bus.iwait, bus.dwait, bus.iload} !== {2'b01, 32'h12345678})
            $display("FAIL if_access: got %b%b %h want 01 12345678", bus.iwait, bus.dwait, bus.iload); else passed++;
        go_idle();
    endtask

    task automatic test_priority();
        go_idle();
        bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = BUSY;
        cyc(); settle();
        total++; if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait} !== {1'b1, 32'h100, 2'b11})
            $display("FAIL pri_dgrant: got %b %h %b%b want 1 100 11", bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait); else passed++;
        cyc(); bus.ramstate = ACCESS; settle();
        total++; if ({bus.iwait, bus.dwait} !== 2'b10)
            $display("FAIL pri_daccess: got %b want 10", {bus.iwait, bus.dwait}); else passed++;
        cyc(); bus.dREN = 0; bus.ramstate = BUSY; settle();
        total++; if (bus.iwait !== 1'b1) $display("FAIL pri_ihold: got %b want 1", bus.iwait); else passed++;
        cyc(); settle();
        total++; if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'h44})
            $display("FAIL pri_igrant: got %b %h want 1 44", bus.ramREN, bus.ramaddr); else passed++;
        go_idle();
    endtask

    task automatic test_starvation();
        logic [1:0] want [8] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        go_idle();
        bus.iREN = 1; bus.iaddr = 32'h48; bus.dREN = 1; bus.daddr = 32'h104; bus.ramstate = ACCESS;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            settle();
            total++; if ({bus.iwait, bus.dwait} !== want[k])
                $display("FAIL starve_c%0d: got %b want %b", k, {bus.iwait, bus.dwait}, want[k]); else passed++;
        end
        go_idle();
    endtask

    task automatic test_write();
        go_idle();
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF; bus.ramstate = BUSY;
        cyc(); settle();
        total++; if ({bus.ramWEN, bus.ramREN, bus.ramstore} !== {2'b10, 32'hDEADBEEF})
            $display("FAIL write: got %b%b %h want 10 deadbeef", bus.ramWEN, bus.ramREN, bus.ramstore); else passed++;
        go_idle();
    endtask

    task automatic test_error();
        go_idle();
        bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = BUSY;
        for (int k = 0; k < 3; k++) begin
            cyc(); bus.ramstate = ERROR; settle();
            total++; if ({bus.iwait, bus.ramREN} !== 2'b11)
                $display("FAIL err_hold%0d: got %b want 11", k, {bus.iwait, bus.ramREN}); else passed++;
        end
        total++; if (int'(dut.scnt_q) !== m_cnt) $display("FAIL err_scnt: got %0d want %0d", dut.scnt_q, m_cnt); else passed++;
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D; settle();
        total++; if ({bus.iwait, bus.iload} !== {1'b0, 32'hCAFEF00D})
            $display("FAIL err_done: got %b %h want 0 cafef00d", bus.iwait, bus.iload); else passed++;
        go_idle();
    endtask

    task automatic test_random();
        logic [131:0] act, want;
        int r;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            nrst         = ($urandom_range(0, 199) != 0);
            bus.iREN     = ($urandom_range(0, 3) != 0);
            bus.dREN     = $urandom_range(0, 1);
            bus.dWEN     = ($urandom_range(0, 3) == 0);
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            r            = $urandom_range(0, 9);
            bus.ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 8) ? ERROR : FREE;
            settle();
            act  = {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
            want = exp_vec();
            total++; if (act !== want) $display("FAIL rnd_out@%0d: got %h want %h", n, act, want); else passed++;
            total++; if (int'(dut.scnt_q) !== m_cnt) $display("FAIL rnd_scnt@%0d: got %0d want %0d", n, dut.scnt_q, m_cnt); else passed++;
            total++; if (bus.ramREN && bus.ramWEN) $display("FAIL rnd_strobes@%0d: got 11 want not both", n); else passed++;
            total++; if (!bus.iwait && !bus.dwait) $display("FAIL rnd_waits@%0d: got 00 want not both", n); else passed++;
        end
        cyc(); nrst = 1;
    endtask

    initial begin
        nrst = 0;
        clear_inputs();
        test_reset();
        test_reset_mid();
        test_ifetch();
        test_priority();
        test_starvation();
        test_write();
        test_error();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
